// File: rtl/loopback_tx_gen.sv
// Transmit-side pattern source for the loopback BER path: PRBS7/15/31 or a
// fixed repeating word, with periodic bit-error injection and TX counters.
module loopback_tx_gen #(
  parameter int n_pat    = 16,
  parameter int n_period = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [1:0]          mode,
  input  logic [1:0]          pat_sel,
  input  logic [30:0]         seed,
  input  logic [n_pat-1:0]    fixed_pat,
  input  logic [n_period-1:0] err_period,
  output logic                data_tx,
  output logic                tx_valid,
  output logic [63:0]         total_bits,
  output logic [63:0]         err_bits
);

  localparam int PTR_W = (n_pat > 1) ? $clog2(n_pat) : 1;
  localparam logic [1:0] MODE_RESET = 2'b00;
  localparam logic [1:0] SEL_PRBS7  = 2'b00;
  localparam logic [1:0] SEL_PRBS15 = 2'b01;
  localparam logic [1:0] SEL_PRBS31 = 2'b10;

  // LOADED means the pattern settings and LFSR have been latched at least
  // once since reset; until then every edge behaves as IDLE.
  typedef enum logic {ST_UNLOADED, ST_LOADED} state_t;

  state_t              st_q, st_d;
  logic [30:0]         lfsr_q, lfsr_d, seed_m;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [n_period-1:0] cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [n_pat-1:0]    pat_q, pat_d;
  logic [63:0]         tot_d, err_d;
  logic                data_d, valid_d;
  logic                run, test, raw, inj;

  assign run  = (st_q == ST_LOADED) && (mode != MODE_RESET);
  assign test = run && mode[1];

  always_comb begin
    st_d    = ST_LOADED;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pat_d   = pat_q;
    tot_d   = total_bits;
    err_d   = err_bits;
    valid_d = 1'b0;
    raw     = 1'b0;
    inj     = 1'b0;
    seed_m  = seed;

    if (!run) begin
      sel_d = pat_sel;
      pat_d = fixed_pat;
      case (pat_sel)
        SEL_PRBS7:  seed_m = {24'd0, seed[6:0]};
        SEL_PRBS15: seed_m = {16'd0, seed[14:0]};
        default:    seed_m = seed;
      endcase
      // An all-zero LFSR would lock up, so substitute 1.
      lfsr_d = (seed_m == 31'd0) ? 31'd1 : seed_m;
      ptr_d  = '0;
      cnt_d  = '0;
      tot_d  = '0;
      err_d  = '0;
    end else begin
      valid_d = 1'b1;
      case (sel_q)
        SEL_PRBS7: begin
          raw    = lfsr_q[6];
          lfsr_d = {24'd0, lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
        SEL_PRBS15: begin
          raw    = lfsr_q[14];
          lfsr_d = {16'd0, lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
        SEL_PRBS31: begin
          raw    = lfsr_q[30];
          lfsr_d = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
        end
        default: begin
          raw   = pat_q[ptr_q];
          ptr_d = (ptr_q == PTR_W'(n_pat - 1)) ? '0 : ptr_q + 1'b1;
        end
      endcase

      if (test) begin
        tot_d = total_bits + 64'd1;
        // >= rather than == so a period shrunk below cnt fires on the next bit.
        if (err_period == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= err_period - 1'b1) begin
          inj   = 1'b1;
          cnt_d = '0;
          err_d = err_bits + 64'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
    data_d = raw ^ inj;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st_q       <= ST_UNLOADED;
      lfsr_q     <= 31'd1;
      ptr_q      <= '0;
      cnt_q      <= '0;
      sel_q      <= 2'b00;
      pat_q      <= '0;
      total_bits <= '0;
      err_bits   <= '0;
      data_tx    <= 1'b0;
      tx_valid   <= 1'b0;
    end else begin
      st_q       <= st_d;
      lfsr_q     <= lfsr_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      pat_q      <= pat_d;
      total_bits <= tot_d;
      err_bits   <= err_d;
      data_tx    <= data_d;
      tx_valid   <= valid_d;
    end
  end

endmodule
